// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - iterative restoring divider for DIV/DIVU/REM/REMU
// One trial subtraction per cycle through a fixed-subtract adder_substracter.

module adder_substracter #(
  parameter int WIDTH = 33
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             sub_i,
  output logic [WIDTH-1:0] result_o,
  output logic             carry_o
);
  logic [WIDTH:0] sum;

  // In subtract mode carry_o is the borrow out of the top bit.
  always_comb begin
    sum = '0;
    if (sub_i) sum = {1'b0, a_i} - {1'b0, b_i};
    else       sum = {1'b0, a_i} + {1'b0, b_i};
  end

  assign result_o = sum[WIDTH-1:0];
  assign carry_o  = sum[WIDTH];
endmodule

module seq_divider #(
  parameter int NUMBER_OF_BITS = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      is_signed,
  input  logic [NUMBER_OF_BITS-1:0] dividend,
  input  logic [NUMBER_OF_BITS-1:0] divisor,
  output logic                      busy,
  output logic                      done,
  output logic [NUMBER_OF_BITS-1:0] quotient,
  output logic [NUMBER_OF_BITS-1:0] remainder,
  output logic                      div_by_zero
);
  localparam int N  = NUMBER_OF_BITS;
  localparam int W  = N + 1;
  localparam int CW = $clog2(N);

  typedef enum logic [2:0] {IDLE, PREP, DIVIDE, FIX, DONE} state_t;

  state_t          state_q, state_d;
  logic            signed_q, signed_d;
  logic [N-1:0]    dvd_q, dvd_d;
  logic [N-1:0]    dvs_q, dvs_d;
  logic [W-1:0]    rem_q, rem_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            qneg_q, qneg_d;
  logic            rneg_q, rneg_d;
  logic [N-1:0]    quo_q, quo_d;
  logic [N-1:0]    remo_q, remo_d;
  logic            dbz_q, dbz_d;

  logic [W-1:0]    shifted;
  logic [W-1:0]    diff;
  logic            borrow;
  logic [W-1:0]    r_next;
  logic [N-1:0]    q_next;
  logic [N-1:0]    dvd_abs, dvs_abs;
  logic            unused_rem_msb;

  // The partial remainder never reaches the divisor, so its top bit stays clear.
  assign shifted        = {rem_q[N-1:0], dvd_q[N-1]};
  assign unused_rem_msb = rem_q[N];

  adder_substracter #(.WIDTH(W)) u_sub (
    .a_i      (shifted),
    .b_i      ({1'b0, dvs_q}),
    .sub_i    (1'b1),
    .result_o (diff),
    .carry_o  (borrow)
  );

  assign r_next  = borrow ? shifted : diff;
  assign q_next  = {dvd_q[N-2:0], ~borrow};
  assign dvd_abs = (signed_q && dvd_q[N-1]) ? -dvd_q : dvd_q;
  assign dvs_abs = (signed_q && dvs_q[N-1]) ? -dvs_q : dvs_q;

  always_comb begin
    state_d  = state_q;
    signed_d = signed_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    quo_d    = quo_q;
    remo_d   = remo_q;
    dbz_d    = dbz_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          dvd_d    = dividend;
          dvs_d    = divisor;
          signed_d = is_signed;
          state_d  = PREP;
        end else begin
          state_d  = IDLE;
        end
      end
      PREP: begin
        qneg_d = signed_q & (dvd_q[N-1] ^ dvs_q[N-1]);
        rneg_d = signed_q & dvd_q[N-1];
        rem_d  = '0;
        cnt_d  = CW'(N - 1);
        dvd_d  = dvd_abs;
        dvs_d  = dvs_abs;
        if (dvs_q == '0) begin
          quo_d   = '1;
          remo_d  = dvd_q;
          dbz_d   = 1'b1;
          state_d = DONE;
        end else if (signed_q && dvd_q == {1'b1, {(N-1){1'b0}}} && dvs_q == '1) begin
          quo_d   = dvd_q;
          remo_d  = '0;
          dbz_d   = 1'b0;
          state_d = DONE;
        end else begin
          state_d = DIVIDE;
        end
      end
      DIVIDE: begin
        rem_d = r_next;
        dvd_d = q_next;
        cnt_d = cnt_q - 1'b1;
        if (cnt_d == '0) state_d = FIX;
      end
      FIX: begin
        // Final quotient bit is resolved here, folded into the sign fix-up.
        quo_d   = qneg_q ? -q_next : q_next;
        remo_d  = rneg_q ? -r_next[N-1:0] : r_next[N-1:0];
        dbz_d   = 1'b0;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      signed_q <= 1'b0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      quo_q    <= '0;
      remo_q   <= '0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      signed_q <= signed_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      quo_q    <= quo_d;
      remo_q   <= remo_d;
      dbz_q    <= dbz_d;
    end
  end

  assign busy        = (state_q == PREP) || (state_q == DIVIDE) || (state_q == FIX);
  assign done        = (state_q == DONE);
  assign quotient    = quo_q;
  assign remainder   = remo_q;
  assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - directed self-checking bench for seq_divider
module tb_seq_divider;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        is_signed = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        busy, done, div_by_zero;
  logic [31:0] quotient, remainder;
  int          errors = 0;
  int          checks = 0;

  seq_divider #(.NUMBER_OF_BITS(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Edges are counted including the edge that samples start.
  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic s, input logic [31:0] eq, input logic [31:0] er,
                       input logic edbz, input int elat, input int inj);
    int lat;
    int busy_cnt;
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b; is_signed = s;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    busy_cnt = busy ? 1 : 0;
    while (!done && lat < 60) begin
      if (lat == inj) begin
        @(negedge clk);
        start = 1'b1; dividend = 32'd9; divisor = 32'd3; is_signed = 1'b0;
      end
      @(posedge clk); #1;
      start = 1'b0;
      lat++;
      if (busy) busy_cnt++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(elat));
    chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(elat - 1));
    chk({tag, "_quotient"}, quotient, eq);
    chk({tag, "_remainder"}, remainder, er);
    chk({tag, "_dbz"}, {31'd0, div_by_zero}, {31'd0, edbz});
  endtask

  initial begin
    int seen_done;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_quotient", quotient, 32'd0);
    chk("reset_remainder", remainder, 32'd0);
    chk("reset_dbz", {31'd0, div_by_zero}, 32'd0);
    @(negedge clk); rst = 1'b0;

    do_op("u100_7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 34, -1);
    @(posedge clk); #1;
    chk("done_pulse_width", {31'd0, done}, 32'd0);
    chk("held_quotient", quotient, 32'd14);
    chk("held_remainder", remainder, 32'd2);

    do_op("s_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 34, -1);
    do_op("s_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 1'b0, 34, -1);
    do_op("u5_0", 32'd5, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd5, 1'b1, 2, -1);
    do_op("s5_0", 32'd5, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'd5, 1'b1, 2, -1);
    do_op("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0, 2, -1);
    do_op("u_ovf_ops", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'h8000_0000, 1'b0, 34, -1);
    do_op("zero_dvd", 32'd0, 32'd5, 1'b0, 32'd0, 32'd0, 1'b0, 34, -1);
    do_op("div_one", 32'd12345, 32'd1, 1'b1, 32'd12345, 32'd0, 1'b0, 34, -1);
    do_op("dvs_gt", 32'd3, 32'd10, 1'b0, 32'd0, 32'd3, 1'b0, 34, -1);

    // Start while busy is ignored; the follow-up start lands in the DONE cycle.
    do_op("busy_ign", 32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b0, 34, 10);
    chk("in_done_cycle", {31'd0, done}, 32'd1);
    do_op("done_restart", 32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0, 34, -1);

    // Abort mid-operation with reset.
    @(negedge clk);
    start = 1'b1; dividend = 32'd100; divisor = 32'd7; is_signed = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_quotient", quotient, 32'd0);
    chk("abort_remainder", remainder, 32'd0);
    @(negedge clk); rst = 1'b0;
    seen_done = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) seen_done++;
    end
    chk("abort_no_done", 32'(seen_done), 32'd0);

    // Reset and start together: reset wins.
    @(negedge clk);
    rst = 1'b1; start = 1'b1; dividend = 32'd50; divisor = 32'd5;
    @(posedge clk); #1;
    chk("rst_start_busy", {31'd0, busy}, 32'd0);
    @(negedge clk); rst = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    chk("rst_start_idle", {31'd0, busy}, 32'd0);

    do_op("after_abort", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 34, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
